// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end blocks: default image geometry,
// streamer FSM state encoding and a width helper.
package cnn_pkg;

    localparam int I_F_BW_DEFAULT = 32'd8;
    localparam int IX_DEFAULT     = 32'd28;
    localparam int IY_DEFAULT     = 32'd28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STREAM = 2'b01,
        ST_FLUSH  = 2'b10
    } stream_state_e;

    // Counter/address width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Single-write, single-read frame memory. The read port is registered; rd_clr
// loads zero into the read register without touching the array.
module frame_ram
    import cnn_pkg::*;
#(
    parameter int DEPTH = 32'd784,
    parameter int WIDTH = 32'd8,
    localparam int AW   = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array: no reset, addresses beyond DEPTH are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; clear wins over a read in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_streamer.sv
// Streams a stored frame row-major with sof/eol/last framing and stall support.
// Define PIXEL_STREAMER_PAD_EN to wrap the image in a PAD-wide zero border.
module pixel_streamer
    import cnn_pkg::*;
#(
    parameter int I_F_BW = I_F_BW_DEFAULT,
    parameter int IX     = IX_DEFAULT,
    parameter int IY     = IY_DEFAULT,
    parameter int PAD    = 32'd2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_wr_en,
    input  logic [$clog2(IX*IY)-1:0]  i_wr_addr,
    input  logic [I_F_BW-1:0]         i_wr_data,
    input  logic                      i_start,
    input  logic                      i_stall,
    output logic                      o_busy,
    output logic                      o_out_valid,
    output logic [I_F_BW-1:0]         o_out_pixel,
    output logic                      o_sof,
    output logic                      o_eol,
    output logic                      o_last
);

    localparam int AW = $clog2(IX*IY);
`ifdef PIXEL_STREAMER_PAD_EN
    localparam int BORDER = PAD;
`else
    // PAD only takes effect when the border feature is built in.
    localparam int BORDER = 32'sd0 * PAD;
`endif
    localparam int OW = IX + 32'sd2 * BORDER;
    localparam int OH = IY + 32'sd2 * BORDER;
    localparam int XW = clog2_min1(OW);
    localparam int YW = clog2_min1(OH);
    localparam logic [XW-1:0] X_LAST = XW'(OW - 32'sd1);
    localparam logic [YW-1:0] Y_LAST = YW'(OH - 32'sd1);

    stream_state_e   state_r;
    logic [XW-1:0]   x_cnt_r;
    logic [YW-1:0]   y_cnt_r;
    logic            issue_s;
    logic            in_img_s;
    logic [AW-1:0]   rd_addr_s;
    logic            ram_wr_en_s;
    logic            ram_rd_en_s;
    logic            ram_rd_clr_s;

    assign issue_s      = (state_r == ST_STREAM) && !i_stall;
    assign ram_wr_en_s  = i_wr_en && !o_busy;
    assign ram_rd_en_s  = issue_s && in_img_s;
    assign ram_rd_clr_s = issue_s && !in_img_s;

    // Map the output position to a RAM address; border positions never read.
    always_comb begin
        in_img_s  = 1'b0;
        rd_addr_s = '0;
        if ((int'(x_cnt_r) >= BORDER) && (int'(x_cnt_r) < BORDER + IX) &&
            (int'(y_cnt_r) >= BORDER) && (int'(y_cnt_r) < BORDER + IY)) begin
            in_img_s  = 1'b1;
            rd_addr_s = AW'((int'(y_cnt_r) - BORDER) * IX + (int'(x_cnt_r) - BORDER));
        end else begin
            in_img_s  = 1'b0;
            rd_addr_s = '0;
        end
    end

    // Sequencer: state, scan counters and the framing flags that ride with
    // the RAM read register, so every output is aligned one cycle after issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            x_cnt_r     <= '0;
            y_cnt_r     <= '0;
            o_busy      <= 1'b0;
            o_out_valid <= 1'b0;
            o_sof       <= 1'b0;
            o_eol       <= 1'b0;
            o_last      <= 1'b0;
        end else begin
            o_out_valid <= 1'b0;
            o_sof       <= 1'b0;
            o_eol       <= 1'b0;
            o_last      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    x_cnt_r <= '0;
                    y_cnt_r <= '0;
                    if (i_start) begin
                        state_r <= ST_STREAM;
                        o_busy  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (!i_stall) begin
                        o_out_valid <= 1'b1;
                        o_sof       <= (x_cnt_r == '0) && (y_cnt_r == '0);
                        o_eol       <= (x_cnt_r == X_LAST);
                        o_last      <= (x_cnt_r == X_LAST) && (y_cnt_r == Y_LAST);
                        if (x_cnt_r == X_LAST) begin
                            x_cnt_r <= '0;
                            if (y_cnt_r == Y_LAST) begin
                                y_cnt_r <= '0;
                                state_r <= ST_FLUSH;
                            end else begin
                                y_cnt_r <= y_cnt_r + YW'(1);
                            end
                        end else begin
                            x_cnt_r <= x_cnt_r + XW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    frame_ram #(
        .DEPTH (IX * IY),
        .WIDTH (I_F_BW)
    ) u_frame_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (ram_wr_en_s),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_en   (ram_rd_en_s),
        .rd_clr  (ram_rd_clr_s),
        .rd_addr (rd_addr_s),
        .rd_data (o_out_pixel)
    );

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer: frames are pushed as expected beats,
// a negedge monitor pops and compares every valid output.
module tb_pixel_streamer;

    localparam int IX  = 28;
    localparam int IY  = 28;
    localparam int PAD = 2;
    localparam int AW  = $clog2(IX*IY);
`ifdef PIXEL_STREAMER_PAD_EN
    localparam int BRD = PAD;
`else
    localparam int BRD = 0;
`endif
    localparam int OW = IX + 2*BRD;
    localparam int OH = IY + 2*BRD;
    localparam int NPIX = OW*OH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_wr_en = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [7:0]    i_wr_data = '0;
    logic          i_start = 1'b0;
    logic          i_stall = 1'b0;
    logic          o_busy, o_out_valid, o_sof, o_eol, o_last;
    logic [7:0]    o_out_pixel;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       last;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] img [IX*IY];
    int         checks = 0;
    int         errors = 0;

    pixel_streamer #(.I_F_BW(8), .IX(IX), .IY(IY), .PAD(PAD)) dut (
        .clk(clk), .reset_n(reset_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_start(i_start), .i_stall(i_stall),
        .o_busy(o_busy), .o_out_valid(o_out_valid), .o_out_pixel(o_out_pixel),
        .o_sof(o_sof), .o_eol(o_eol), .o_last(o_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_pix(input int x, input int y);
        if (x < BRD || x >= BRD + IX || y < BRD || y >= BRD + IY) return 8'h00;
        return img[(y - BRD) * IX + (x - BRD)];
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int y = 0; y < OH; y++) begin
            for (int x = 0; x < OW; x++) begin
                e.pix  = model_pix(x, y);
                e.sof  = (x == 0) && (y == 0);
                e.eol  = (x == OW - 1);
                e.last = (x == OW - 1) && (y == OH - 1);
                sb_q.push_back(e);
            end
        end
    endtask

    // Monitor: compare every valid beat against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && o_out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("beat", {21'd0, o_out_pixel, o_sof, o_eol, o_last}, {21'd0, e});
            end
        end else if (reset_n) begin
            chk("flags_when_invalid", {29'd0, o_sof, o_eol, o_last}, 32'd0);
        end
    end

    // One frame: start, then per-cycle stall/duplicate-start/write/reset stimulus.
    task automatic run_frame(input int st_lo, input int st_hi, input int dup_at,
                             input int wr_at, input int rst_at,
                             output int nvalid, output int gaps, output int first_s,
                             output int last_s, output int busy_low_s);
        int s;
        push_frame();
        nvalid = 0; gaps = 0; first_s = -1; last_s = -1; busy_low_s = -1;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
        chk("no_valid_at_start", {31'd0, o_out_valid}, 32'd0);
        s = 0;
        while (s < 3000) begin
            if (o_out_valid) begin
                nvalid++;
                if (first_s < 0) first_s = s;
                if (o_last) last_s = s;
            end else if (first_s >= 0 && last_s < 0) begin
                gaps++;
            end
            if (!o_busy) begin
                busy_low_s = s;
                break;
            end
            if (rst_at > 0 && nvalid == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_valid", {31'd0, o_out_valid}, 32'd0);
                chk("rst_busy", {31'd0, o_busy}, 32'd0);
                chk("rst_pixel", {24'd0, o_out_pixel}, 32'd0);
                chk("sb_left_at_abort", sb_q.size(), NPIX - rst_at);
                sb_q.delete();
                i_stall = 1'b0; i_start = 1'b0; i_wr_en = 1'b0;
                return;
            end
            i_stall   = (s >= st_lo) && (s <= st_hi);
            i_start   = (s == dup_at);
            i_wr_en   = (s == wr_at);
            i_wr_addr = AW'(5);
            i_wr_data = 8'hAA;
            @(negedge clk);
            s++;
        end
        i_stall = 1'b0; i_start = 1'b0; i_wr_en = 1'b0;
        if (busy_low_s < 0) chk("frame_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int nv, gp, fs, ls, bl;
        for (int i = 0; i < IX*IY; i++) img[i] = 8'(i);

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_valid", {31'd0, o_out_valid}, 32'd0);
        chk("reset_flags", {29'd0, o_sof, o_eol, o_last}, 32'd0);
        chk("reset_pixel", {24'd0, o_out_pixel}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < IX*IY; i++) begin
            @(negedge clk);
            i_wr_en = 1'b1; i_wr_addr = AW'(i); i_wr_data = img[i];
        end
        @(negedge clk); i_wr_en = 1'b0;

        // Unstalled frame with a write to address 5 attempted mid-frame.
        run_frame(-1, -1, -1, 100, 0, nv, gp, fs, ls, bl);
        chk("f1_count", nv, NPIX);
        chk("f1_gaps", gp, 0);
        chk("f1_first_valid", fs, 1);
        chk("f1_last_cycle", ls, NPIX);
        chk("f1_busy_fall", bl, ls + 1);

        // Stall cycles 10..14 of streaming; the re-stream also proves address 5 held.
        run_frame(10, 14, -1, -1, 0, nv, gp, fs, ls, bl);
        chk("f2_count", nv, NPIX);
        chk("f2_gaps", gp, 5);
        chk("f2_first_valid", fs, 1);
        chk("f2_busy_fall", bl, ls + 1);

        // Duplicate start at cycle 50, reset after the 400th pixel.
        run_frame(-1, -1, 50, -1, 400, nv, gp, fs, ls, bl);
        repeat (2) begin
            @(negedge clk);
            chk("hold_reset_valid", {31'd0, o_out_valid}, 32'd0);
            chk("hold_reset_busy", {31'd0, o_busy}, 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(-1, -1, -1, -1, 0, nv, gp, fs, ls, bl);
        chk("f4_count", nv, NPIX);
        chk("f4_gaps", gp, 0);
        chk("f4_busy_fall", bl, ls + 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
